instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction requests. It drives `INSTRUCTION` and `BUSYWAIT` into the IF stage and the IF_ID register. On a miss it holds `BUSYWAIT` high, freezing the PC and the IF_ID register, and refills a 128-bit block from instruction memory. It sits between the PC/fetch logic and the instruction memory.

## Interface
- `INDEX_BITS`, default 3: log2 of the block count (8 blocks of 4 words, 16 bytes each).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `PC` in 32: fetch byte address. Bits [1:0] are ignored, [3:2] are the word offset, [3+INDEX_BITS:4] are the index, and the rest is the tag.
- `READ` in 1: fetch request; held high while `PC` is valid.
- `INSTRUCTION` out 32: fetched instruction; valid when `READ`=1 and `BUSYWAIT`=0.
- `BUSYWAIT` out 1: stall to the PC, the IF_ID register and the hazard logic.
- `MEM_READ` out 1: block read request to instruction memory.
- `MEM_ADDRESS` out 28: block address, equal to PC[31:4] of the latched miss.
- `MEM_READDATA` in 128: refill block; word n is at [32n+31:32n].
- `MEM_BUSYWAIT` in 1: memory busy; data is valid in the first `MEM_READ` cycle where this is 0.

## Operation
- Storage per block: a 128-bit data field, a (28−INDEX_BITS)-bit tag and a valid bit.
- Hit = `READ` & valid[index] & (tag[index] == PC tag). The hit is evaluated combinationally in the same cycle the PC is presented.
- FSM states:
  - **IDLE**:
    - Hit: `INSTRUCTION` = the selected word, `BUSYWAIT`=0.
    - `READ` & !hit: `BUSYWAIT`=1, latch PC[31:4] into the miss register, go to MEM_READ.
    - `READ`=0: `BUSYWAIT`=0, `INSTRUCTION`=0.
  - **MEM_READ**:
    - `MEM_READ`=1, `MEM_ADDRESS` = the miss register, `BUSYWAIT`=1.
    - Stays while `MEM_BUSYWAIT`=1.
    - When `MEM_BUSYWAIT`=0: write `MEM_READDATA`, the latched tag and valid=1 into the latched index at that edge, then go to UPDATE.
  - **UPDATE**: `MEM_READ`=0, `BUSYWAIT`=1; one cycle, then IDLE. The hit is re-evaluated against the current `PC`.
- `BUSYWAIT` = (state≠IDLE) | (`READ` & !hit).
- If `PC` changes during a miss (branch redirect), the fill completes for the latched block. The new PC is looked up on return to IDLE and may miss again.
- `READ` falling mid-miss does not abort the fill.
- A fill replaces the indexed block unconditionally. No write path exists.

## Timing
- Reset, applied at the edge while `RESET`=1:
  - All valid bits are cleared and the state goes to IDLE.
  - `MEM_READ`=0.
  - `BUSYWAIT` = `READ` (every lookup misses), and `INSTRUCTION`=0 until the first fill.
- Reset mid-miss:
  - The fill is abandoned and the next state is IDLE.
  - `MEM_READ` drops in the cycle after the reset edge.
  - No array write takes place.
- Hit latency: 0 cycles (combinational).
- Miss penalty, when memory returns in the k-th `MEM_READ` cycle (k≥1):
  - `BUSYWAIT` is high for exactly k+2 cycles: miss cycle, k × MEM_READ, UPDATE.
  - The hit and instruction appear in cycle k+2.
- `MEM_READ` is high for exactly k consecutive cycles per miss.
- `MEM_ADDRESS` is stable for the whole MEM_READ interval.

## Structure
- Package `icache_pkg`:
  - State enum `{IDLE, MEM_READ, UPDATE}`.
  - `BLOCK_WIDTH`=128 and `WORD_WIDTH`=32.
  - Functions for the tag width and the index and tag fields.
- Sub-module `instruction_cache_array`:
  - Data, tag and valid storage with asynchronous read and synchronous write on fill.
  - Synchronous clear of the valid bits on `RESET`.
- The top level holds the FSM, the miss register, the hit compare and the word mux.

## Test plan
- **Cold fetch:** reset, then `READ`=1, `PC`=0x00000000, with memory returning at k=4.
  - `BUSYWAIT` is high for 6 cycles.
  - `MEM_ADDRESS`=0x0000000.
  - Then `INSTRUCTION` = `MEM_READDATA`[31:0] with `BUSYWAIT`=0.
- **Sequential hits:** `PC`=0x4, 0x8, 0xC on consecutive cycles → `BUSYWAIT`=0 every cycle, words 1, 2, 3 returned, `MEM_READ` never asserted.
- **Conflict eviction:** `PC`=0x80 (index 0, tag 1) → miss and refill with `MEM_ADDRESS`=0x0000008. A following `PC`=0x0 misses again.
- **Redirect during miss:** start a miss at 0x100, then change `PC` to 0x40 during MEM_READ.
  - Fill completes for `MEM_ADDRESS`=0x0000010.
  - UPDATE is followed by a new miss for 0x0000004.
- **Reset mid-miss:** assert `RESET` during MEM_READ.
  - `MEM_READ`=0 next cycle.
  - A later fetch of the same PC misses, since no partial fill occurred.
- **Idle:** `READ`=0 with any `PC` → `BUSYWAIT`=0, `INSTRUCTION`=0, no memory request.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// icache_pkg: shared types, widths and PC field helpers for the instruction cache.
package icache_pkg;
  localparam int BLOCK_WIDTH = 128;
  localparam int WORD_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
  function automatic int tag_width(int index_bits);
    return 28 - index_bits;
  endfunction
  function automatic logic [31:0] pc_index(logic [31:0] pc, int index_bits);
    return (pc >> 4) & ((32'd1 << index_bits) - 32'd1);
  endfunction
  function automatic logic [31:0] pc_tag(logic [31:0] pc, int index_bits);
    return pc >> (4 + index_bits);
  endfunction
endpackage

// File: rtl/instruction_cache_array.sv
// instruction_cache_array: block data, tag and valid storage; async read, sync fill write.
module instruction_cache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS = 25
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [INDEX_BITS-1:0]  rd_index,
  output logic [BLOCK_WIDTH-1:0] rd_data,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]    wr_tag,
  input  logic [BLOCK_WIDTH-1:0] wr_data
);
  localparam int BLOCKS = 1 << INDEX_BITS;
  logic [BLOCKS-1:0][BLOCK_WIDTH-1:0] data_q, data_d;
  logic [BLOCKS-1:0][TAG_BITS-1:0]    tag_q, tag_d;
  logic [BLOCKS-1:0]                  valid_q, valid_d;
  always_comb begin
    data_d = data_q;
    tag_d = tag_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d[wr_index] = wr_data;
      tag_d[wr_index] = wr_tag;
      valid_d[wr_index] = 1'b1;
    end
    if (RESET) valid_d = '0;
  end
  always_ff @(posedge CLK) begin
    data_q <= data_d;
    tag_q <= tag_d;
    valid_q <= valid_d;
  end
  assign rd_data = data_q[rd_index];
  assign rd_tag = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache with miss FSM, hit compare and word select.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            PC,
  input  logic                   READ,
  output logic [WORD_WIDTH-1:0]  INSTRUCTION,
  output logic                   BUSYWAIT,
  output logic                   MEM_READ,
  output logic [27:0]            MEM_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
);
  localparam int TAG_BITS = tag_width(INDEX_BITS);
  state_t state_q, state_d;
  logic [27:0] miss_q, miss_d;
  logic [INDEX_BITS-1:0] pc_idx, wr_idx;
  logic [TAG_BITS-1:0] pc_tg, wr_tg, rd_tag;
  logic [BLOCK_WIDTH-1:0] rd_data;
  logic rd_valid, hit, wr_en;
  assign pc_idx = INDEX_BITS'(pc_index(PC, INDEX_BITS));
  assign pc_tg = TAG_BITS'(pc_tag(PC, INDEX_BITS));
  assign wr_idx = INDEX_BITS'(pc_index({miss_q, 4'b0}, INDEX_BITS));
  assign wr_tg = TAG_BITS'(pc_tag({miss_q, 4'b0}, INDEX_BITS));
  instruction_cache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS(TAG_BITS)
  ) u_array (
    .CLK(CLK),
    .RESET(RESET),
    .rd_index(pc_idx),
    .rd_data(rd_data),
    .rd_tag(rd_tag),
    .rd_valid(rd_valid),
    .wr_en(wr_en),
    .wr_index(wr_idx),
    .wr_tag(wr_tg),
    .wr_data(MEM_READDATA)
  );
  assign hit = READ & rd_valid & (rd_tag == pc_tg);
  assign INSTRUCTION = hit ? rd_data[32*PC[3:2] +: WORD_WIDTH] : '0;
  assign MEM_ADDRESS = miss_q;
  assign MEM_READ = (state_q == icache_pkg::MEM_READ);
  // A reset on the return edge must not commit the abandoned fill.
  assign wr_en = MEM_READ & ~MEM_BUSYWAIT & ~RESET;
  always_comb begin
    state_d = state_q;
    miss_d = miss_q;
    BUSYWAIT = 1'b1;
    case (state_q)
      IDLE: begin
        BUSYWAIT = READ & ~hit;
        if (READ & ~hit) begin
          state_d = icache_pkg::MEM_READ;
          miss_d = PC[31:4];
        end
      end
      icache_pkg::MEM_READ: state_d = MEM_BUSYWAIT ? icache_pkg::MEM_READ : UPDATE;
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    state_q <= RESET ? IDLE : state_d;
    miss_q <= RESET ? '0 : miss_d;
  end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: table-driven per-cycle checks of the instruction cache against a latency-controlled memory model.
module tb_instruction_cache;
  logic CLK = 1'b0;
  logic RESET, READ;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic BUSYWAIT, MEM_READ, MEM_BUSYWAIT;
  logic [27:0] MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  int mem_lat = 1;
  int cnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic rd;
    logic [31:0] pc;
    int lat;
    logic busy;
    logic [31:0] instr;
    logic mrd;
    logic [27:0] addr;
  } vec_t;
  vec_t vq[$];

  instruction_cache dut (
    .CLK(CLK),
    .RESET(RESET),
    .PC(PC),
    .READ(READ),
    .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] w(logic [27:0] b, int n);
    logic [1:0] nn;
    nn = 2'(n);
    return {b, nn, 2'b00} ^ 32'hC0DE0000;
  endfunction

  function automatic logic [127:0] blk(logic [27:0] b);
    logic [127:0] d;
    for (int n = 0; n < 4; n++) d[32*n +: 32] = w(b, n);
    return d;
  endfunction

  always @(posedge CLK) cnt <= MEM_READ ? cnt + 1 : 0;
  assign MEM_BUSYWAIT = !(MEM_READ && cnt == mem_lat - 1);
  assign MEM_READDATA = MEM_BUSYWAIT ? {4{32'hBAD0BAD0}} : blk(MEM_ADDRESS);

  function automatic vec_t mk(logic rd, logic [31:0] pc, int lat, logic busy, logic [31:0] instr, logic mrd, logic [27:0] addr);
    vec_t v;
    v.rd = rd; v.pc = pc; v.lat = lat; v.busy = busy; v.instr = instr; v.mrd = mrd; v.addr = addr;
    return v;
  endfunction

  task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic apply(string name, int step, vec_t v);
    READ = v.rd;
    PC = v.pc;
    mem_lat = v.lat;
    #4;
    chk({name, ".busywait"}, step, {31'b0, BUSYWAIT}, {31'b0, v.busy});
    chk({name, ".instruction"}, step, INSTRUCTION, v.instr);
    chk({name, ".mem_read"}, step, {31'b0, MEM_READ}, {31'b0, v.mrd});
    if (v.mrd) chk({name, ".mem_address"}, step, {4'b0, MEM_ADDRESS}, {4'b0, v.addr});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    READ = 1'b1;
    PC = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    // idle, then cold fetch with k=4: 6 busy cycles
    vq.push_back(mk(0, 32'h0, 4, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'h0, 4, 1, 0, 0, 0));
    repeat (4) vq.push_back(mk(1, 32'h0, 4, 1, 0, 1, 28'h0));
    vq.push_back(mk(1, 32'h0, 4, 1, w(0, 0), 0, 0));
    vq.push_back(mk(1, 32'h0, 4, 0, w(0, 0), 0, 0));
    vq.push_back(mk(1, 32'h4, 4, 0, w(0, 1), 0, 0));
    vq.push_back(mk(1, 32'h8, 4, 0, w(0, 2), 0, 0));
    vq.push_back(mk(1, 32'hC, 4, 0, w(0, 3), 0, 0));
    // conflict eviction of index 0, then refetch of 0x0
    vq.push_back(mk(1, 32'h80, 2, 1, 0, 0, 0));
    repeat (2) vq.push_back(mk(1, 32'h80, 2, 1, 0, 1, 28'h8));
    vq.push_back(mk(1, 32'h80, 2, 1, w(8, 0), 0, 0));
    vq.push_back(mk(1, 32'h84, 2, 0, w(8, 1), 0, 0));
    vq.push_back(mk(1, 32'h0, 1, 1, 0, 0, 0));
    vq.push_back(mk(1, 32'h0, 1, 1, 0, 1, 28'h0));
    vq.push_back(mk(1, 32'h0, 1, 1, w(0, 0), 0, 0));
    vq.push_back(mk(1, 32'hC, 1, 0, w(0, 3), 0, 0));
    // idle with valid and invalid PCs
    vq.push_back(mk(0, 32'h1234, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'hC, 1, 0, 0, 0, 0));
    foreach (vq[i]) apply("table", i, vq[i]);

    // redirect during miss: 0x100 fill completes, then 0x40 misses
    apply("redirect", 0, mk(1, 32'h100, 3, 1, 0, 0, 0));
    for (int i = 1; i <= 3; i++) apply("redirect", i, mk(1, 32'h40, 3, 1, 0, 1, 28'h10));
    apply("redirect", 4, mk(1, 32'h40, 3, 1, 0, 0, 0));
    apply("redirect", 5, mk(1, 32'h40, 1, 1, 0, 0, 0));
    apply("redirect", 6, mk(1, 32'h40, 1, 1, 0, 1, 28'h4));
    apply("redirect", 7, mk(1, 32'h40, 1, 1, w(4, 0), 0, 0));
    apply("redirect", 8, mk(1, 32'h44, 1, 0, w(4, 1), 0, 0));
    apply("redirect", 9, mk(1, 32'h108, 1, 0, w(28'h10, 2), 0, 0));

    // reset on the very edge memory returns: fill dropped
    apply("rst_miss", 0, mk(1, 32'h200, 2, 1, 0, 0, 0));
    apply("rst_miss", 1, mk(1, 32'h200, 2, 1, 0, 1, 28'h20));
    RESET = 1'b1;
    apply("rst_miss", 2, mk(1, 32'h200, 2, 1, 0, 1, 28'h20));
    RESET = 1'b0;
    apply("rst_miss", 3, mk(1, 32'h200, 1, 1, 0, 0, 0));
    apply("rst_miss", 4, mk(1, 32'h200, 1, 1, 0, 1, 28'h20));
    apply("rst_miss", 5, mk(1, 32'h200, 1, 1, w(28'h20, 0), 0, 0));
    apply("rst_miss", 6, mk(1, 32'h20C, 1, 0, w(28'h20, 3), 0, 0));
    apply("rst_miss", 7, mk(1, 32'h44, 1, 1, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
